// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline datapath registers: data width and
// reset/NOP words usable as RESET_VAL at stage boundaries.
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] ZERO_WORD = 32'h0000_0000;
  // addi x0, x0, 0 -- canonical RISC-V NOP, used when a boundary must reset to a bubble
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stage.sv
// One enable-gated register slice: loads d when en is high, holds otherwise,
// and clears asynchronously to RESET_VAL while rst is low.
module pipeline_stage
  import pipeline_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Capture on enable, hold on stall; reset clears without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VAL;
    end else if (en) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_latch.sv
// Parameterised inter-stage pipeline register: STAGES cascaded enable-gated
// slices sharing clock, reset and enable; Out comes straight from the last flop.
module pipeline_latch
  import pipeline_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               STAGES    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out
);

  if (WIDTH < 1) begin : g_bad_width
    $error("pipeline_latch: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("pipeline_latch: STAGES must be >= 1");
  end

  // w_chain[0] is the upstream input; w_chain[i+1] is the output of slice i.
  logic [STAGES:0][WIDTH-1:0] w_chain;

  assign w_chain[0] = In;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipeline_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .en (en),
      .d  (w_chain[i]),
      .q  (w_chain[i+1])
    );
  end

  assign Out = w_chain[STAGES];

endmodule

// File: tb/tb_pipeline_latch.sv
// Scoreboard bench for pipeline_latch: three configurations (default, 3-deep,
// 8-bit with A5 reset value) driven from a directed vector table.
module tb_pipeline_latch;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        en_a, en_b, en_c;
  logic [31:0] in_a, in_b, out_a, out_b;
  logic [7:0]  in_c, out_c;

  always #5 clk = ~clk;

  pipeline_latch u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .In(in_a), .Out(out_a)
  );

  pipeline_latch #(.WIDTH(32), .RESET_VAL(32'h0000_0000), .STAGES(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .In(in_b), .Out(out_b)
  );

  pipeline_latch #(.WIDTH(8), .RESET_VAL(8'hA5), .STAGES(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .In(in_c), .Out(out_c)
  );

  typedef struct {
    int          dut;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  typedef struct {
    logic ea; logic [31:0] ia; logic [31:0] xa;
    logic eb; logic [31:0] ib; logic [31:0] xb;
    logic ec; logic [7:0]  ic; logic [7:0]  xc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;
  event async_ev;

  task automatic push(input int d, input logic [31:0] v, input string tag);
    exp_t e;
    e.dut = d;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: after every rising edge (or an async event) compare all pending expectations.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(posedge clk or async_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          0:       act = out_a;
          1:       act = out_b;
          default: act = {24'h00_0000, out_c};
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h at %0t", e.tag, act, e.exp, $time);
        end
      end
    end
  end

  // Stimulus: reset phase, then directed table; a and c take an async reset in cycle 5.
  initial begin
    vecs[0] = '{1'b1, 32'h228, 32'h228, 1'b1, 32'd1,        32'd0, 1'b1, 8'hFF, 8'hFF};
    vecs[1] = '{1'b0, 32'h42,  32'h228, 1'b1, 32'd2,        32'd0, 1'b0, 8'h3C, 8'hFF};
    vecs[2] = '{1'b0, 32'h42,  32'h228, 1'b0, 32'hxxxxxxxx, 32'd0, 1'b1, 8'h3C, 8'h3C};
    vecs[3] = '{1'b0, 32'h42,  32'h228, 1'b0, 32'hxxxxxxxx, 32'd0, 1'b1, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 32'h42,  32'h42,  1'b1, 32'd3,        32'd1, 1'b1, 8'h81, 8'h81};
    vecs[5] = '{1'b1, 32'h99,  32'h0,   1'b1, 32'd4,        32'd2, 1'b1, 8'h77, 8'hA5};
    vecs[6] = '{1'b0, 32'h42,  32'h0,   1'b1, 32'd0,        32'd3, 1'b1, 8'h5A, 8'h5A};
    vecs[7] = '{1'b0, 32'h42,  32'h0,   1'b1, 32'd0,        32'd4, 1'b0, 8'h11, 8'h5A};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
    in_a  = 32'h228; in_b = 32'h0; in_c = 8'hFF;

    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      push(0, 32'h0,  $sformatf("reset_a[%0d]", k));
      push(1, 32'h0,  $sformatf("reset_b[%0d]", k));
      push(2, 32'hA5, $sformatf("reset_c[%0d]", k));
    end

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      end
      if (k == 6) begin
        rst_a = 1'b1; rst_c = 1'b1;
      end
      en_a = vecs[k].ea; in_a = vecs[k].ia;
      en_b = vecs[k].eb; in_b = vecs[k].ib;
      en_c = vecs[k].ec; in_c = vecs[k].ic;
      if (k == 5) begin
        #2;
        rst_a = 1'b0;
        rst_c = 1'b0;
        push(0, 32'h0,  "async_a");
        push(2, 32'hA5, "async_c");
        -> async_ev;
        #2;
      end
      push(0, vecs[k].xa,             $sformatf("a[%0d]", k));
      push(1, vecs[k].xb,             $sformatf("b[%0d]", k));
      push(2, {24'h00_0000, vecs[k].xc}, $sformatf("c[%0d]", k));
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
